// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES encryption datapath: requests round keys
// 0..NR in order, issues load/update strobes, and hands off the final ciphertext.
module aes_round_ctrl #(
  parameter int unsigned NR = 10  // 10, 12 or 14 cipher rounds
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       key_req,
  output logic [3:0] key_idx,
  input  logic       key_ack,
  output logic       ld_state,
  output logic       upd_state,
  output logic       mix_en,
  output logic [3:0] round,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [1:0] {IDLE, KEY, DONE} state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    in_ready  = 1'b0;
    key_req   = 1'b0;
    key_idx   = '0;
    ld_state  = 1'b0;
    upd_state = 1'b0;
    mix_en    = 1'b0;
    out_valid = 1'b0;

    // Outputs are forced quiet while reset is held, even before the flops clear.
    if (rst) begin
      unique case (state_q)
        IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            state_d = KEY;
            round_d = '0;
          end
        end
        KEY: begin
          key_req = 1'b1;
          key_idx = round_q;
          if (key_ack) begin
            if (round_q == '0) begin
              ld_state = 1'b1;
              round_d  = 4'd1;
            end else begin
              upd_state = 1'b1;
              // Final round skips mixColumns and parks the counter at NR.
              if (round_q == LAST_ROUND) begin
                state_d = DONE;
              end else begin
                mix_en  = 1'b1;
                round_d = round_q + 4'd1;
              end
            end
          end
        end
        DONE: begin
          out_valid = 1'b1;
          if (out_ready) begin
            state_d = IDLE;
            round_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          round_d = '0;
        end
      endcase
    end
  end

  assign round = rst ? round_q : '0;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: NR=10 and NR=14 instances share stimulus and are compared
// each cycle against a transaction-level model, plus directed latency/stall/reset scenarios.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic rst, in_valid, key_ack, out_ready;

  logic       o_ir[2], o_kr[2], o_ld[2], o_up[2], o_mx[2], o_ov[2];
  logic [3:0] o_ki[2], o_rd[2];

  int n_checks = 0;
  int n_fail   = 0;

  // Model: per instance, whether a block is in flight, finished, and how many keys it has consumed.
  bit m_busy[2], m_done[2];
  int m_keys[2];

  int blk_cyc;
  int first_ld[2], first_ov[2], upd_cnt[2], nomix_cnt[2];

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(10)) dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_ir[0]),
    .key_req(o_kr[0]), .key_idx(o_ki[0]), .key_ack(key_ack),
    .ld_state(o_ld[0]), .upd_state(o_up[0]), .mix_en(o_mx[0]),
    .round(o_rd[0]), .out_valid(o_ov[0]), .out_ready(out_ready)
  );

  aes_round_ctrl #(.NR(14)) dut14 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_ir[1]),
    .key_req(o_kr[1]), .key_idx(o_ki[1]), .key_ack(key_ack),
    .ld_state(o_ld[1]), .upd_state(o_up[1]), .mix_en(o_mx[1]),
    .round(o_rd[1]), .out_valid(o_ov[1]), .out_ready(out_ready)
  );

  function automatic int nr_of(int i);
    return (i == 0) ? 10 : 14;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_stats();
    blk_cyc = 0;
    for (int i = 0; i < 2; i++) begin
      first_ld[i] = -1; first_ov[i] = -1; upd_cnt[i] = 0; nomix_cnt[i] = 0;
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      int  nr = nr_of(i);
      bit  e_ir = 0, e_kr = 0, e_ld = 0, e_up = 0, e_mx = 0, e_ov = 0;
      int  e_ki = 0, e_rd = 0;
      string p = $sformatf("nr%0d.", nr);
      if (rst) begin
        if (m_done[i]) begin
          e_ov = 1; e_rd = nr;
        end else if (m_busy[i]) begin
          e_kr = 1; e_ki = m_keys[i]; e_rd = m_keys[i];
          if (key_ack) begin
            e_ld = (m_keys[i] == 0);
            e_up = (m_keys[i] > 0);
            e_mx = (m_keys[i] > 0) && (m_keys[i] < nr);
          end
        end else begin
          e_ir = 1;
        end
      end
      check({p, "in_ready"},  32'(o_ir[i]), 32'(e_ir));
      check({p, "key_req"},   32'(o_kr[i]), 32'(e_kr));
      check({p, "key_idx"},   32'(o_ki[i]), 32'(e_ki));
      check({p, "ld_state"},  32'(o_ld[i]), 32'(e_ld));
      check({p, "upd_state"}, 32'(o_up[i]), 32'(e_up));
      check({p, "mix_en"},    32'(o_mx[i]), 32'(e_mx));
      check({p, "round"},     32'(o_rd[i]), 32'(e_rd));
      check({p, "out_valid"}, 32'(o_ov[i]), 32'(e_ov));
      if (o_ld[i] === 1'b1 && first_ld[i] < 0) first_ld[i] = blk_cyc;
      if (o_ov[i] === 1'b1 && first_ov[i] < 0) first_ov[i] = blk_cyc;
      if (o_up[i] === 1'b1) upd_cnt[i]++;
      if (o_up[i] === 1'b1 && o_mx[i] !== 1'b1) nomix_cnt[i]++;
    end
    blk_cyc++;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        m_busy[i] = 0; m_done[i] = 0; m_keys[i] = 0;
      end else if (m_done[i]) begin
        if (out_ready) m_done[i] = 0;
      end else if (m_busy[i]) begin
        if (key_ack) begin
          if (m_keys[i] == nr_of(i)) begin
            m_busy[i] = 0; m_done[i] = 1;
          end else begin
            m_keys[i]++;
          end
        end
      end else if (in_valid) begin
        m_busy[i] = 1; m_keys[i] = 0;
      end
    end
    #1;
  endtask

  // Accept one block at block cycle 0, optionally withholding key_ack, then verify timing.
  task automatic run_block(int stall_at, int stall_len, string name);
    clear_stats();
    in_valid = 1; key_ack = 1; out_ready = 1;
    cycle();
    in_valid = 0;
    for (int c = 1; c < 40; c++) begin
      key_ack = !(c >= stall_at && c < stall_at + stall_len);
      cycle();
    end
    key_ack = 1;
    for (int i = 0; i < 2; i++) begin
      string p = $sformatf("%s.nr%0d.", name, nr_of(i));
      check({p, "ld_cycle"},    32'(first_ld[i]),  32'd1);
      check({p, "ov_cycle"},    32'(first_ov[i]),  32'(nr_of(i) + 2 + stall_len));
      check({p, "upd_pulses"},  32'(upd_cnt[i]),   32'(nr_of(i)));
      check({p, "nomix_upds"},  32'(nomix_cnt[i]), 32'd1);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_done[i] = 0; m_keys[i] = 0;
    end
    clear_stats();
    rst = 0; in_valid = 0; key_ack = 0; out_ready = 0;
    #1;
    repeat (2) cycle();
    rst = 1;
    cycle();

    run_block(0, 0, "nominal");
    run_block(5, 3, "stall_r4");

    // Backpressure in DONE with in_valid held high.
    in_valid = 1; key_ack = 1; out_ready = 0;
    cycle();
    repeat (22) cycle();
    check("bp.nr14.out_valid_held", 32'(o_ov[1]), 32'd1);
    check("bp.nr14.in_ready_low",   32'(o_ir[1]), 32'd0);
    in_valid = 0; out_ready = 1;
    repeat (2) cycle();

    // Reset while round 6 is in progress, then a fresh block.
    in_valid = 1; cycle();
    in_valid = 0;
    repeat (6) cycle();
    check("mid.nr10.round_before_rst", 32'(o_rd[0]), 32'd6);
    rst = 0; cycle();
    rst = 1; cycle();
    run_block(0, 0, "after_rst");

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 99) != 0);
      in_valid  = $urandom_range(0, 1);
      key_ack   = ($urandom_range(0, 9) < 7);
      out_ready = $urandom_range(0, 1);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter: NR, default 10, number of cipher rounds; legal values 10, 12, 14 only.
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset; synchronous, active-low.
REQ-004 Port: in_valid  in  1  plaintext block present on datapath input.
REQ-005 Port: in_ready  out  1  controller idle, accepts a new block.
REQ-006 Port: key_req  out  1  round-key request to key schedule.
REQ-007 Port: key_idx  out  4  index of requested round key, 0..NR.
REQ-008 Port: key_ack  in  1  requested round key valid on datapath key input this cycle.
REQ-009 Port: ld_state  out  1  datapath state reg <= plaintext XOR roundkey (initial addRoundKey).
REQ-010 Port: upd_state  out  1  datapath state reg <= round(state, roundkey).
REQ-011 Port: mix_en  out  1  round includes mixColumns; 0 selects bypass.
REQ-012 Port: round  out  4  current round number, 0 when idle.
REQ-013 Port: out_valid  out  1  ciphertext in datapath state reg is final.
REQ-014 Port: out_ready  in  1  consumer accepts ciphertext.

Function
REQ-015 FSM states SHALL be IDLE, KEY, DONE; encoding free.
REQ-016 IDLE: in_ready=1 (0 while rst low); in_valid&in_ready -> KEY, round<=0.
REQ-017 KEY: key_req=1, key_idx=round; key_req and key_idx SHALL stay stable until key_ack.
REQ-018 KEY, round=0, key_ack=1: ld_state=1 same cycle (combinational on key_ack), round<=1, stay KEY.
REQ-019 KEY, 1<=round<NR, key_ack=1: upd_state=1, mix_en=1, round<=round+1, stay KEY.
REQ-020 KEY, round=NR, key_ack=1: upd_state=1, mix_en=0, -> DONE, round held at NR.
REQ-021 KEY, key_ack=0: no ld_state/upd_state pulse, no state change; wait unbounded.
REQ-022 ld_state and upd_state SHALL never be 1 in the same cycle; at most one pulse per key_ack.
REQ-023 mix_en SHALL be 0 whenever upd_state=0.
REQ-024 key_ack outside KEY SHALL be ignored.
REQ-025 DONE: out_valid=1 held until out_valid&out_ready; then -> IDLE, round<=0.
REQ-026 in_valid during KEY/DONE SHALL be ignored (in_ready=0); no queuing.
REQ-027 Latency with key_ack tied 1: accept at cycle t -> ld_state at t+1, upd_state t+2..t+NR+1, out_valid first at t+NR+2 (t+12 for NR=10).
REQ-028 Throughput: next block accepted no earlier than cycle after out handshake.
REQ-029 round counter SHALL not exceed NR; no wrap.

Reset
REQ-030 rst=0 at rising edge: FSM -> IDLE, round=0, key_idx=0, all of key_req, ld_state, upd_state, mix_en, out_valid=0, in_ready=0 during reset.
REQ-031 Reset mid-operation (KEY or DONE) SHALL abandon block; no pulses in reset cycle; in_ready=1 first cycle after rst=1.

Verification
REQ-032 NR=10, key_ack=1, out_ready=1, one block at t=0 -> ld_state @1, upd_state @2..11, mix_en=0 only @11, out_valid @12, in_ready @13.
REQ-033 key_ack stalled 3 cycles at round=4 -> key_req=1, key_idx=4 held stable, no upd_state for those cycles, out_valid delayed 3 cycles.
REQ-034 out_ready=0 for 5 cycles in DONE, in_valid=1 throughout -> out_valid held, in_ready=0, no new accept until handshake.
REQ-035 rst=0 asserted at round=6 -> next cycle IDLE, all outputs 0, round=0; fresh block afterwards completes with correct latency.
REQ-036 NR=14, key_ack=1 -> key_idx sequence 0..14, 14 upd_state pulses, out_valid @16.
